// File: rtl/fpu_txn_capture_pkg.sv
// Shared types for the FPU_in transaction capture block: bus enums, tracked
// entry and completed-record structs, output-register state encoding.
package fpu_txn_capture_pkg;

  localparam int CAP_FP_W  = 32;
  localparam int CAP_LAT_W = 8;

  typedef enum logic [2:0] {
    FPU_ADD  = 3'd0,
    FPU_SUB  = 3'd1,
    FPU_MUL  = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_I2F  = 3'd4,
    FPU_F2I  = 3'd5,
    FPU_SQRT = 3'd6,
    FPU_RSV  = 3'd7
  } fpu_op_t;

  typedef enum logic [1:0] {
    RND_NEAREST = 2'd0,
    RND_ZERO    = 2'd1,
    RND_UP      = 2'd2,
    RND_DOWN    = 2'd3
  } fpu_rnd_t;

  typedef struct packed {
    fpu_op_t               op;
    fpu_rnd_t              rmode;
    logic [CAP_FP_W-1:0]   a;
    logic [CAP_FP_W-1:0]   b;
    logic [CAP_LAT_W-1:0]  ts;
  } fpu_cap_entry_t;

  typedef struct packed {
    fpu_op_t               op;
    fpu_rnd_t              rmode;
    logic [CAP_FP_W-1:0]   a;
    logic [CAP_FP_W-1:0]   b;
    logic [CAP_FP_W-1:0]   result;
    logic [CAP_LAT_W-1:0]  latency;
  } fpu_cap_rec_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Modular age; correct across timestamp wrap while ages stay below 2**W.
  function automatic logic [CAP_LAT_W-1:0] ts_age(input logic [CAP_LAT_W-1:0] now_ts,
                                                  input logic [CAP_LAT_W-1:0] then_ts);
    return now_ts - then_ts;
  endfunction

endpackage

// File: rtl/fpu_txn_capture_if.sv
// FPU_in bus plus the monitor record channel produced by the capture block.
interface fpu_txn_capture_if #(
  parameter int FP_WIDTH = 32,
  parameter int LAT_W    = 8
);
  logic                start;
  logic [2:0]          op;
  logic [1:0]          rmode;
  logic [FP_WIDTH-1:0] a;
  logic [FP_WIDTH-1:0] b;
  logic                ready;
  logic [FP_WIDTH-1:0] result;

  // Record channel: a record transfers on a clock where mon_valid & mon_ready;
  // once raised, mon_valid and all mon_* fields hold until that transfer.
  logic                mon_valid;
  logic                mon_ready;
  logic [2:0]          mon_op;
  logic [1:0]          mon_rmode;
  logic [FP_WIDTH-1:0] mon_a;
  logic [FP_WIDTH-1:0] mon_b;
  logic [FP_WIDTH-1:0] mon_result;
  logic [LAT_W-1:0]    mon_latency;

  modport master (
    output start, op, rmode, a, b, ready, result, mon_ready,
    input  mon_valid, mon_op, mon_rmode, mon_a, mon_b, mon_result, mon_latency
  );

  modport slave (
    input  start, op, rmode, a, b, ready, result, mon_ready,
    output mon_valid, mon_op, mon_rmode, mon_a, mon_b, mon_result, mon_latency
  );
endinterface

// File: rtl/fpu_cap_fifo.sv
// In-order tracking FIFO of outstanding ops; pointers carry an extra wrap bit
// so full and empty are distinguishable. Push and pop may share a cycle.
module fpu_cap_fifo
  import fpu_txn_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  fpu_cap_entry_t         wdata,
  output fpu_cap_entry_t         rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  fpu_cap_entry_t mem_q [DEPTH];
  fpu_cap_entry_t mem_d [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/fpu_txn_capture.sv
// Passive FPU_in tracker: queues issued ops, pairs each result with the oldest
// outstanding op, and presents one registered record with its latency.
module fpu_txn_capture
  import fpu_txn_capture_pkg::*;
#(
  parameter int FP_WIDTH = CAP_FP_W,
  parameter int DEPTH    = 4,
  parameter int LAT_W    = CAP_LAT_W,
  parameter int TIMEOUT  = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr_err,
  fpu_txn_capture_if.slave       bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err_ovf,
  output logic                   err_orphan,
  output logic                   err_timeout,
  output logic                   err_drop,
  output out_state_t             dbg_out_state
);
  logic [LAT_W-1:0] ts_q, ts_d;
  logic [LAT_W-1:0] head_age;
  fpu_cap_entry_t   wdata, head;
  fpu_cap_rec_t     comp_rec, rec_q, rec_d;
  out_state_t       state_q, state_d;
  logic             push, pop, full, empty, comp, accept;
  logic             bus_start, bus_ready;
  logic             ev_ovf, ev_orphan, ev_tmo, ev_drop;
  logic             err_ovf_q, err_orphan_q, err_timeout_q, err_drop_q;
  logic             err_ovf_d, err_orphan_d, err_timeout_d, err_drop_d;

  fpu_cap_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign bus_start = en & bus.start;
  assign bus_ready = en & bus.ready;
  assign ts_d      = ts_q + LAT_W'(1);
  assign head_age  = ts_age(ts_q, head.ts);
  assign wdata     = '{op: fpu_op_t'(bus.op), rmode: fpu_rnd_t'(bus.rmode),
                       a: bus.a[FP_WIDTH-1:0], b: bus.b[FP_WIDTH-1:0], ts: ts_q};

  // Pairing: a ready always completes against the head; the timeout check only
  // applies on cycles without a ready, and is independent of en.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    comp      = 1'b0;
    ev_ovf    = 1'b0;
    ev_orphan = 1'b0;
    ev_tmo    = 1'b0;
    comp_rec  = '0;
    if (bus_ready) begin
      if (!empty) begin
        pop      = 1'b1;
        push     = bus_start;
        comp     = 1'b1;
        comp_rec = '{op: head.op, rmode: head.rmode, a: head.a, b: head.b,
                     result: bus.result, latency: head_age};
      end else if (bus_start) begin
        comp     = 1'b1;
        comp_rec = '{op: wdata.op, rmode: wdata.rmode, a: wdata.a, b: wdata.b,
                     result: bus.result, latency: '0};
      end else begin
        ev_orphan = 1'b1;
      end
    end else begin
      if (!empty && (head_age >= LAT_W'(TIMEOUT))) begin
        pop    = 1'b1;
        ev_tmo = 1'b1;
      end
      if (bus_start) begin
        if (full) ev_ovf = 1'b1;
        else      push   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    ev_drop = 1'b0;
    accept  = (state_q == OUT_FULL) && bus.mon_ready;
    case (state_q)
      OUT_EMPTY: begin
        if (comp) begin
          state_d = OUT_FULL;
          rec_d   = comp_rec;
        end
      end
      OUT_FULL: begin
        if (comp) begin
          if (accept) rec_d   = comp_rec;
          else        ev_drop = 1'b1;
        end else if (accept) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // Sticky flags: a same-cycle event overrides clr_err.
  always_comb begin
    err_ovf_d     = (err_ovf_q     & ~clr_err) | ev_ovf;
    err_orphan_d  = (err_orphan_q  & ~clr_err) | ev_orphan;
    err_timeout_d = (err_timeout_q & ~clr_err) | ev_tmo;
    err_drop_d    = (err_drop_q    & ~clr_err) | ev_drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q          <= '0;
      state_q       <= OUT_EMPTY;
      rec_q         <= '0;
      err_ovf_q     <= 1'b0;
      err_orphan_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_drop_q    <= 1'b0;
    end else begin
      ts_q          <= ts_d;
      state_q       <= state_d;
      rec_q         <= rec_d;
      err_ovf_q     <= err_ovf_d;
      err_orphan_q  <= err_orphan_d;
      err_timeout_q <= err_timeout_d;
      err_drop_q    <= err_drop_d;
    end
  end

  assign bus.mon_valid   = (state_q == OUT_FULL);
  assign bus.mon_op      = rec_q.op;
  assign bus.mon_rmode   = rec_q.rmode;
  assign bus.mon_a       = rec_q.a;
  assign bus.mon_b       = rec_q.b;
  assign bus.mon_result  = rec_q.result;
  assign bus.mon_latency = rec_q.latency;
  assign err_ovf         = err_ovf_q;
  assign err_orphan      = err_orphan_q;
  assign err_timeout     = err_timeout_q;
  assign err_drop        = err_drop_q;
  assign dbg_out_state   = state_q;
endmodule
